// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the register-file write port plus a busy scoreboard
module regfile_write_arbiter #(
    parameter int NREG = 16,
    parameter int DW   = 32
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            Req0Valid,
    output logic            Req0Ready,
    input  logic [3:0]      Req0Reg,
    input  logic [DW-1:0]   Req0Data,
    input  logic            Req1Valid,
    output logic            Req1Ready,
    input  logic [3:0]      Req1Reg,
    input  logic [DW-1:0]   Req1Data,
    output logic [DW-1:0]   RfData,
    output logic [3:0]      RfDec,
    output logic            RfLd,
    input  logic            IssValid,
    input  logic [3:0]      IssReg,
    output logic            IssReady,
    input  logic [3:0]      SA,
    input  logic [3:0]      SB,
    input  logic            UseA,
    input  logic            UseB,
    output logic            Stall,
    output logic [NREG-1:0] Busy
);
    logic            last;
    logic            xfer;
    logic [NREG-1:0] setMask;
    logic [NREG-1:0] clrMask;

    // grant: a lone requester wins; on a tie the one that did not win last time wins
    always_comb begin
        Req0Ready = Req0Valid & (~Req1Valid | last);
        Req1Ready = Req1Valid & (~Req0Valid | ~last);
        xfer      = Req0Ready | Req1Ready;
        IssReady  = ~Busy[IssReg];
        Stall     = (UseA & Busy[SA]) | (UseB & Busy[SB]);
        setMask   = (IssValid & IssReady) ? NREG'(1) << IssReg : '0;
        clrMask   = RfLd ? NREG'(1) << RfDec : '0;
    end

    // write port stage: register the winning transfer and pulse the load enable for one cycle
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            last   <= 1'b1;
            RfLd   <= 1'b0;
            RfDec  <= '0;
            RfData <= '0;
        end else begin
            RfLd <= xfer;
            if (xfer) begin
                RfDec  <= Req1Ready ? Req1Reg : Req0Reg;
                RfData <= Req1Ready ? Req1Data : Req0Data;
                last   <= Req1Ready;
            end
        end
    end

    // scoreboard: clear on writeback, set on issue; set is applied last so it wins a collision
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr)
            Busy <= '0;
        else
            Busy <= (Busy & ~clrMask) | setMask;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, write port, scoreboard and reset
module tb_regfile_write_arbiter;
    logic        Clk = 1'b0;
    logic        Clr = 1'b1;
    logic        Req0Valid = 0, Req1Valid = 0;
    logic        Req0Ready, Req1Ready;
    logic [3:0]  Req0Reg = 0, Req1Reg = 0;
    logic [31:0] Req0Data = 0, Req1Data = 0;
    logic [31:0] RfData;
    logic [3:0]  RfDec;
    logic        RfLd;
    logic        IssValid = 0;
    logic [3:0]  IssReg = 0;
    logic        IssReady;
    logic [3:0]  SA = 0, SB = 0;
    logic        UseA = 0, UseB = 0;
    logic        Stall;
    logic [15:0] Busy;
    int          passCnt = 0;
    int          checkCnt = 0;

    regfile_write_arbiter #(.NREG(16), .DW(32)) dut (
        .Clk(Clk), .Clr(Clr),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Reg(Req0Reg), .Req0Data(Req0Data),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Reg(Req1Reg), .Req1Data(Req1Data),
        .RfData(RfData), .RfDec(RfDec), .RfLd(RfLd),
        .IssValid(IssValid), .IssReg(IssReg), .IssReady(IssReady),
        .SA(SA), .SB(SB), .UseA(UseA), .UseB(UseB), .Stall(Stall), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #1 Clr = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(Busy), 0);
        check("rst_rfld", 32'(RfLd), 0);
        check("rst_rfdec", 32'(RfDec), 0);
        check("rst_rfdata", RfData, 0);
        check("rst_stall", 32'(Stall), 0);
        check("rst_issready", 32'(IssReady), 1);
        Clr = 1'b1;
        Req0Valid = 1; Req0Reg = 5; Req0Data = 32'hDEADBEEF;
        #1;
        check("t1_r0ready", 32'(Req0Ready), 1);
        check("t1_r1ready", 32'(Req1Ready), 0);
        tick();
        Req0Valid = 0;
        check("t1_rfld", 32'(RfLd), 1);
        check("t1_rfdec", 32'(RfDec), 5);
        check("t1_rfdata", RfData, 32'hDEADBEEF);
        tick();
        check("t1_rfld_off", 32'(RfLd), 0);
        check("t1_rfdec_hold", 32'(RfDec), 5);
        Req1Valid = 1; Req1Reg = 9; Req1Data = 32'h99;
        #1;
        check("solo1_r1ready", 32'(Req1Ready), 1);
        tick();
        check("solo1_rfdec", 32'(RfDec), 9);
        Req0Valid = 1; Req0Reg = 1; Req0Data = 32'h11111111;
        Req1Valid = 1; Req1Reg = 2; Req1Data = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_r0ready", 32'(Req0Ready), (k % 2 == 0) ? 1 : 0);
            check("rr_r1ready", 32'(Req1Ready), (k % 2 == 1) ? 1 : 0);
            tick();
            check("rr_rfld", 32'(RfLd), 1);
            check("rr_rfdec", 32'(RfDec), (k % 2 == 0) ? 1 : 2);
            check("rr_rfdata", RfData, (k % 2 == 0) ? 32'h11111111 : 32'h22222222);
        end
        Req0Valid = 0; Req1Valid = 0;
        tick();
        check("rr_rfld_off", 32'(RfLd), 0);
        IssValid = 1; IssReg = 3;
        #1;
        check("iss3_ready", 32'(IssReady), 1);
        tick();
        IssValid = 0;
        SA = 3; UseA = 1;
        #1;
        check("iss3_busy", 32'(Busy), 32'h8);
        check("haz_stall", 32'(Stall), 1);
        UseA = 0;
        #1;
        check("haz_unused", 32'(Stall), 0);
        UseA = 1;
        Req1Valid = 1; Req1Reg = 3; Req1Data = 32'h33;
        #1;
        check("haz_r1ready", 32'(Req1Ready), 1);
        check("haz_stall_pend", 32'(Stall), 1);
        tick();
        Req1Valid = 0;
        #1;
        check("haz_rfld", 32'(RfLd), 1);
        check("haz_rfdec", 32'(RfDec), 3);
        check("haz_stall_ld", 32'(Stall), 1);
        tick();
        check("haz_busy_clr", 32'(Busy), 0);
        check("haz_stall_off", 32'(Stall), 0);
        UseA = 0;
        IssValid = 1; IssReg = 7;
        tick();
        #1;
        check("iss7_busy", 32'(Busy), 32'h80);
        check("iss7_blocked", 32'(IssReady), 0);
        tick();
        check("iss7_busy_keep", 32'(Busy), 32'h80);
        Req0Valid = 1; Req0Reg = 7; Req0Data = 32'h77;
        #1;
        check("w7_r0ready", 32'(Req0Ready), 1);
        tick();
        Req0Valid = 0;
        #1;
        check("w7_rfld", 32'(RfLd), 1);
        check("w7_rfdec", 32'(RfDec), 7);
        check("w7_issready", 32'(IssReady), 0);
        tick();
        IssValid = 0;
        #1;
        check("w7_cleared", 32'(Busy), 0);
        check("w7_issready_free", 32'(IssReady), 1);
        Req1Valid = 1; Req1Reg = 7; Req1Data = 32'h70;
        #1;
        check("sw_r1ready", 32'(Req1Ready), 1);
        tick();
        Req1Valid = 0;
        IssValid = 1; IssReg = 7;
        #1;
        check("sw_rfld", 32'(RfLd), 1);
        check("sw_issready", 32'(IssReady), 1);
        tick();
        IssValid = 0;
        check("sw_set_wins", 32'(Busy), 32'h80);
        for (int r = 4; r < 7; r++) begin
            IssValid = 1; IssReg = 4'(r);
            tick();
        end
        IssValid = 0;
        check("pre_rst_busy", 32'(Busy), 32'hF0);
        Req1Valid = 1; Req1Reg = 4; Req1Data = 32'h44;
        #1;
        check("pre_rst_r1ready", 32'(Req1Ready), 1);
        #1 Clr = 1'b0;
        #1;
        check("mid_rst_busy", 32'(Busy), 0);
        check("mid_rst_rfld", 32'(RfLd), 0);
        check("mid_rst_rfdec", 32'(RfDec), 0);
        check("mid_rst_rfdata", RfData, 0);
        tick();
        check("mid_rst_nowrite", 32'(RfLd), 0);
        Req1Valid = 0;
        Clr = 1'b1;
        Req0Valid = 1; Req0Reg = 10; Req0Data = 32'hA0;
        Req1Valid = 1; Req1Reg = 11; Req1Data = 32'hB0;
        #1;
        check("post_rst_r0ready", 32'(Req0Ready), 1);
        check("post_rst_r1ready", 32'(Req1Ready), 0);
        tick();
        Req0Valid = 0; Req1Valid = 0;
        check("post_rst_rfld", 32'(RfLd), 1);
        check("post_rst_rfdec", 32'(RfDec), 10);
        check("post_rst_rfdata", RfData, 32'hA0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (data, destination select, load enable) between two writeback requesters: the ALU path and the memory-load path. Arbitration is round-robin with a valid/ready handshake. The block also keeps a 16-entry busy scoreboard so decode can stall on read-after-write hazards against the two read selects. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- NREG, 16, number of architectural registers; fixes scoreboard width and 4-bit selects.
- DW, 32, writeback data width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clr  in  1  asynchronous, active-low reset.
- Req0Valid  in  1  ALU writeback request.
- Req0Ready  out  1  grant to requester 0; a transfer occurs when Valid and Ready are both 1.
- Req0Reg  in  4  destination register for requester 0.
- Req0Data  in  DW  write data for requester 0.
- Req1Valid, Req1Ready, Req1Reg, Req1Data: same as above, for the memory-load writeback.
- RfData  out  DW  to register file write data.
- RfDec  out  4  to register file destination select.
- RfLd  out  1  to register file load enable.
- IssValid  in  1  decode issues an instruction that will write IssReg.
- IssReg  in  4  destination of the issuing instruction.
- IssReady  out  1  issue accepted.
- SA, SB  in  4 each  read selects of the instruction in decode.
- UseA, UseB  in  1 each  the instruction in decode actually reads SA/SB.
- Stall  out  1  read-after-write hazard on a used read select.
- Busy  out  NREG  scoreboard contents.

## Operation
Arbitration:
- The Last pointer is 1 bit and resets to 1, so requester 0 wins the first tie.
- Only one requester valid: that requester is granted.
- Both valid: the requester not equal to Last is granted.
- The granted requester sees Ready = 1 combinationally in the same cycle. The other requester's Ready is 0.
- Ready is never 1 for a requester whose Valid is 0.
- Last updates to the granted index only when a transfer occurs.

Write port:
- A transfer in cycle t registers {Reg, Data} into RfDec/RfData and sets RfLd = 1 during cycle t+1.
- The register file captures the value on the edge that ends cycle t+1.
- RfLd is 0 in any cycle that has no transfer in the previous cycle.
- RfDec and RfData hold their last values when RfLd is 0.
- Back-to-back transfers sustain one write per cycle.

Scoreboard:
- IssReady = ~Busy[IssReg].
- A cycle with IssValid & IssReady sets Busy[IssReg] at the end of that cycle.
- A cycle with RfLd = 1 clears Busy[RfDec] at the end of that cycle.
- Set and clear on the same register in the same cycle: set wins.
- A write to a register whose busy bit is 0 is legal and leaves Busy unchanged.

Hazard:
- Stall = (UseA & Busy[SA]) | (UseB & Busy[SB]), combinational, no bypass.

Reset:
- Outputs after reset: Busy = 0, RfLd = 0, RfDec = 0, RfData = 0, Last = 1, Stall = 0.
- Req0Ready and Req1Ready follow their Valid inputs per the arbitration rules.
- IssReady = 1.
- A transfer accepted in the cycle reset asserts is dropped. No write is emitted.

## Timing
- Request to register-file update: the transfer cycle plus 1 cycle of RfLd.
- Busy set: visible the cycle after issue.
- Busy clear: visible the cycle after RfLd.
- Stall for a pending register deasserts in the cycle after RfLd for that register.
- The ready path is combinational from Valid and Last. It must not depend on Data or Reg.
- Requesters hold Valid/Reg/Data stable until Ready. The block does not check this.

## Test plan
- Reset, then Req0Valid=1, Reg=5, Data=0xDEADBEEF for 1 cycle -> Req0Ready=1 that cycle; next cycle RfLd=1, RfDec=5, RfData=0xDEADBEEF; the cycle after, RfLd=0.
- Both requesters valid for 4 cycles (Reg 1/2, distinct data) -> grants alternate 0,1,0,1; RfLd=1 for 4 consecutive cycles with RfDec 1,2,1,2.
- Issue to R3, then SA=3 with UseA=1 -> Stall=1 until Req1 writes R3; Stall=0 the cycle after RfLd with RfDec=3. With UseA=0 -> Stall=0 throughout.
- Issue to R7 while R7 busy -> IssReady=0, Busy unchanged. In a cycle where RfLd clears R7 while IssValid with IssReg=7 (IssReady=0) -> R7 clears. Separately, with R7 free: issue R7 in the same cycle RfLd writes R7 -> Busy[7] stays 1.
- Assert Clr mid-stream with Busy=0x00F0 and a pending transfer -> Busy=0, RfLd=0, no write after Clr; after release, a tie grants requester 0 first.
